fir_channel_scheduler: RTL and testbench
========================================

Name: fir_channel_scheduler

Overview:
Round-robin scheduler that time-shares one serial FIR MAC datapath (delay-line banks, coefficient ROM, accumulator, output register) between NUM_CH independent sample streams. It accepts one sample per grant and sequences the datapath through load, LENGTH MAC cycles and store. It then flags which channel's result is valid in the datapath output register. It replaces the single-stream control unit when the filter is shared between multiple streams.

Parameters:
WIDTH, 16, sample width in bits
LENGTH, 100, number of taps (MAC cycles per sample), must be at least 2
NUM_CH, 4, number of requesting channels, 2..16
CH_W, $clog2(NUM_CH), channel index width
TAP_W, $clog2(LENGTH), tap address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
enable  in  1  scheduler enable; when low, no new grants are issued
ch_valid  in  NUM_CH  per-channel sample-available flag
ch_data  in  NUM_CH*WIDTH  packed samples; channel i occupies bits [i*WIDTH +: WIDTH]
ch_ready  out  NUM_CH  one-hot accept strobe
dp_in  out  WIDTH  registered sample to the datapath
dp_ch_sel  out  CH_W  delay-line and accumulator bank select
dp_tap_addr  out  TAP_W  coefficient and delay-tap index
dp_shift_enb  out  1  shift dp_in into the bank selected by dp_ch_sel
dp_reset_reg  out  1  clear the accumulator
dp_count_enb  out  1  perform the MAC for dp_tap_addr
dp_register_enb  out  1  load the accumulator into the output register
out_valid  out  1  one-cycle pulse: the output register holds the result for out_ch
out_ch  out  CH_W  channel of the current result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE and RR pointer=0
  - all outputs 0: ch_ready, dp_*, out_valid, out_ch, busy
- Reset mid-operation abandons the sample in flight; no out_valid is produced for it.
- FSM states and transitions:
  - IDLE: grant g = first i at or after pointer (mod NUM_CH) with ch_valid[i]=1.
    - ch_ready[g]=1 combinationally, only when enable=1 and state=IDLE.
    - On handshake (ch_valid[g] & ch_ready[g]): latch dp_in<=ch_data[g], dp_ch_sel<=g, pointer<=(g+1) mod NUM_CH; go to LOAD.
    - With no valid request or enable=0: stay in IDLE, ch_ready=0.
  - LOAD (1 cycle): dp_shift_enb=1, dp_reset_reg=1, dp_tap_addr=0; go to MAC.
  - MAC (LENGTH cycles): dp_count_enb=1, dp_tap_addr counts 0..LENGTH-1.
    - At LENGTH-1 the tap address wraps to 0 and the FSM goes to STORE.
  - STORE (1 cycle): dp_register_enb=1; go to DONE.
  - DONE (1 cycle): out_valid=1, out_ch=dp_ch_sel; go to IDLE.
- Strobe outputs (dp_shift_enb, dp_reset_reg, dp_count_enb, dp_register_enb, out_valid) are Moore, decoded from registered state. They are 0 outside their own state.
- dp_in, dp_ch_sel and out_ch hold their values until the next accept.
- Timing: handshake in cycle T gives LOAD at T+1, MAC from T+2 to T+LENGTH+1, STORE at T+LENGTH+2, out_valid at T+LENGTH+3.
  - Minimum accept-to-accept period is LENGTH+4 cycles.
- Arbitration:
  - Round-robin; a channel holding ch_valid is served within NUM_CH grants.
  - Requests asserted while busy are ignored until IDLE, with no loss of ordering.
- enable falling mid-operation: the current sample completes normally, then no new grant is issued.
- ch_valid dropping in the same cycle as the grant: no handshake occurs and the FSM stays in IDLE.
- Only one ch_ready bit may be high in any cycle.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with all ch_valid=1 -> every output 0. Release rst, enable=1 -> ch_ready=4'b0001 in the first IDLE cycle.
2. Single channel: ch_valid[2]=1 with data 16'h1234, handshake at T -> dp_in=16'h1234 and dp_ch_sel=2 at T+1. dp_count_enb is high for exactly 100 cycles with dp_tap_addr 0..99. dp_register_enb at T+102; out_valid with out_ch=2 at T+103.
3. Round-robin fairness: all four ch_valid held high -> grant order 0,1,2,3,0. Accepts spaced exactly 104 cycles apart.
4. Pointer skip: pointer=1, only ch_valid[3] and ch_valid[0] high -> grant 3 first, then 0.
5. enable deassert: drop enable at T+50 of a run -> that run still produces out_valid at T+103. No further ch_ready until enable=1.
6. Reset mid-MAC: assert rst at T+40 -> all strobes 0 immediately and no out_valid. After release, the next grant starts at channel 0.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one serial FIR MAC datapath between NUM_CH streams.
// Sequences load, LENGTH MAC cycles, store and a result-valid pulse per accepted sample.
module fir_channel_scheduler #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LENGTH = 100,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH),
  parameter int unsigned TAP_W  = $clog2(LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_ready,
  output logic [WIDTH-1:0]        dp_in,
  output logic [CH_W-1:0]         dp_ch_sel,
  output logic [TAP_W-1:0]        dp_tap_addr,
  output logic                    dp_shift_enb,
  output logic                    dp_reset_reg,
  output logic                    dp_count_enb,
  output logic                    dp_register_enb,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic                    busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] MAC   = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  grant_c;
  logic             grant_vld_c;
  logic             accept_c;
  logic [TAP_W-1:0] tap;
  logic             tap_last_c;
  int unsigned      idx;

  // First requesting channel at or after the pointer; lowest offset wins.
  always_comb begin
    grant_c     = '0;
    grant_vld_c = 1'b0;
    idx         = 0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (ch_valid[idx]) begin
        grant_c     = CH_W'(idx);
        grant_vld_c = 1'b1;
      end
    end
  end

  // Accept strobe is combinational so the handshake completes in the IDLE cycle.
  always_comb begin
    accept_c = rst && enable && (state == IDLE) && grant_vld_c;
    ch_ready = '0;
    if (accept_c) begin
      ch_ready = NUM_CH'(1) << grant_c;
    end
  end

  assign tap_last_c  = (tap == TAP_W'(LENGTH - 1));
  assign dp_tap_addr = tap;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = LOAD;
      LOAD:    state_next = MAC;
      MAC:     if (tap_last_c) state_next = STORE;
      STORE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes are registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr             <= '0;
      tap             <= '0;
      dp_in           <= '0;
      dp_ch_sel       <= '0;
      dp_shift_enb    <= 1'b0;
      dp_reset_reg    <= 1'b0;
      dp_count_enb    <= 1'b0;
      dp_register_enb <= 1'b0;
      out_valid       <= 1'b0;
      out_ch          <= '0;
      busy            <= 1'b0;
    end else begin
      if (accept_c) begin
        dp_in     <= ch_data[int'(grant_c)*WIDTH +: WIDTH];
        dp_ch_sel <= grant_c;
        ptr       <= (grant_c == CH_W'(NUM_CH - 1)) ? '0 : grant_c + CH_W'(1);
      end
      if (state == MAC) begin
        tap <= tap_last_c ? '0 : tap + TAP_W'(1);
      end
      if (state_next == DONE) begin
        out_ch <= dp_ch_sel;
      end
      dp_shift_enb    <= (state_next == LOAD);
      dp_reset_reg    <= (state_next == LOAD);
      dp_count_enb    <= (state_next == MAC);
      dp_register_enb <= (state_next == STORE);
      out_valid       <= (state_next == DONE);
      busy            <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler: directed grant sequences, a monitor
// checks grant order, datapath strobe timing and result pulses against queued expectations.
module tb_fir_channel_scheduler;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned LENGTH = 100;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned TAP_W  = 7;

  typedef struct {
    int          ch;
    logic [15:0] data;
    int          acc;
  } res_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    enable = 1'b0;
  logic [NUM_CH-1:0]       ch_valid = '0;
  logic [WIDTH-1:0]        dat [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]       ch_ready;
  logic [WIDTH-1:0]        dp_in;
  logic [CH_W-1:0]         dp_ch_sel;
  logic [TAP_W-1:0]        dp_tap_addr;
  logic                    dp_shift_enb, dp_reset_reg, dp_count_enb, dp_register_enb;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic                    busy;

  res_t res_q[$];
  int   exp_q[$];
  int   acc_cyc[$];
  int   acc_cnt = 0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tap_exp = 0;
  int   mac_cnt = 0;

  fir_channel_scheduler #(
    .WIDTH(WIDTH), .LENGTH(LENGTH), .NUM_CH(NUM_CH), .CH_W(CH_W), .TAP_W(TAP_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .dp_in(dp_in), .dp_ch_sel(dp_ch_sel), .dp_tap_addr(dp_tap_addr),
    .dp_shift_enb(dp_shift_enb), .dp_reset_reg(dp_reset_reg), .dp_count_enb(dp_count_enb),
    .dp_register_enb(dp_register_enb), .out_valid(out_valid), .out_ch(out_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < int'(NUM_CH); i++) ch_data[i*WIDTH +: WIDTH] = dat[i];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("accept_wait", 64'(acc_cnt >= target), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((res_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_wait", 64'(res_q.size()), 64'd0);
  endtask

  // Monitor: grant order, datapath sequencing and result pulses.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      tap_exp = 0;
      mac_cnt = 0;
    end else begin
      chk("ready_onehot", 64'($onehot0(ch_ready)), 64'd1);
      if (|(ch_ready & ch_valid)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 64'(ch_ready), 64'd0);
        end else begin
          res_t r;
          int e;
          e = exp_q.pop_front();
          chk("grant", 64'(ch_ready), 64'(1 << e));
          r.ch = e; r.data = dat[e]; r.acc = cyc;
          res_q.push_back(r);
          acc_cyc.push_back(cyc);
          acc_cnt++;
        end
      end
      if (dp_shift_enb) begin
        chk("load_reset_reg", 64'(dp_reset_reg), 64'd1);
        chk("load_tap", 64'(dp_tap_addr), 64'd0);
        if (res_q.size() > 0) begin
          chk("load_dp_in", 64'(dp_in), 64'(res_q[$].data));
          chk("load_ch_sel", 64'(dp_ch_sel), 64'(res_q[$].ch));
          chk("load_cycle", 64'(cyc), 64'(res_q[$].acc + 1));
        end
        tap_exp = 0;
        mac_cnt = 0;
      end
      if (dp_count_enb) begin
        chk("mac_tap", 64'(dp_tap_addr), 64'(tap_exp));
        tap_exp++;
        mac_cnt++;
      end
      if (dp_register_enb) begin
        chk("mac_count", 64'(mac_cnt), 64'(LENGTH));
        if (res_q.size() > 0) chk("store_cycle", 64'(cyc), 64'(res_q[0].acc + int'(LENGTH) + 2));
      end
      if (out_valid) begin
        if (res_q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("out_ch", 64'(out_ch), 64'(r.ch));
          chk("out_dp_in", 64'(dp_in), 64'(r.data));
          chk("out_cycle", 64'(cyc), 64'(r.acc + int'(LENGTH) + 3));
        end
      end
    end
  end

  initial begin
    int t0;
    int n;
    logic saw;
    for (int i = 0; i < int'(NUM_CH); i++) dat[i] = 16'(16'hA000 + i);

    // Reset with every channel requesting
    rst = 1'b0; enable = 1'b0; ch_valid = '1;
    repeat (3) tick();
    #3;
    chk("rst_ch_ready", 64'(ch_ready), 64'd0);
    chk("rst_dp_in", 64'(dp_in), 64'd0);
    chk("rst_ch_sel", 64'(dp_ch_sel), 64'd0);
    chk("rst_tap", 64'(dp_tap_addr), 64'd0);
    chk("rst_strobes", 64'({dp_shift_enb, dp_reset_reg, dp_count_enb, dp_register_enb}), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Round-robin with all channels held: 0,1,2,3,0 back to back
    exp_q = {0, 1, 2, 3, 0};
    tick();
    rst = 1'b1; enable = 1'b1;
    #3;
    chk("first_grant", 64'(ch_ready), 64'b0001);
    wait_acc(5, 700);
    ch_valid = '0;
    for (int i = 1; i < 5; i++)
      if (acc_cyc.size() > i) chk("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(LENGTH + 4));
    wait_drain(300);

    // Pointer is 1: only channels 3 and 0 request
    exp_q = {3, 0};
    ch_valid = 4'b1001;
    wait_acc(7, 400);
    ch_valid = '0;
    wait_drain(300);

    // Single channel 2
    dat[2] = 16'h1234;
    exp_q = {2};
    ch_valid = 4'b0100;
    wait_acc(8, 50);
    ch_valid = '0;
    wait_drain(300);

    // enable drops mid-run: run completes, no further grants
    dat[1] = 16'h5555;
    exp_q = {1};
    ch_valid = 4'b0010;
    wait_acc(9, 50);
    t0 = acc_cyc[$];
    while (cyc < t0 + 50) tick();
    enable = 1'b0;
    wait_drain(200);
    n = acc_cnt;
    saw = 1'b0;
    repeat (30) begin
      tick();
      #3;
      if (ch_ready != '0) saw = 1'b1;
    end
    chk("no_ready_disabled", 64'(saw), 64'd0);
    chk("no_accept_disabled", 64'(acc_cnt), 64'(n));

    // Reset in the middle of MAC
    dat[1] = 16'h6666;
    exp_q = {1};
    enable = 1'b1;
    wait_acc(10, 50);
    t0 = acc_cyc[$];
    while (cyc < t0 + 40) tick();
    rst = 1'b0;
    #1;
    chk("midrst_count_enb", 64'(dp_count_enb), 64'd0);
    chk("midrst_strobes", 64'({dp_shift_enb, dp_reset_reg, dp_register_enb, out_valid}), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_tap", 64'(dp_tap_addr), 64'd0);
    res_q.delete();
    repeat (2) tick();
    ch_valid = '1;
    exp_q = {0};
    rst = 1'b1;
    wait_acc(11, 50);
    ch_valid = '0;
    wait_drain(300);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("res_q_empty", 64'(res_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
